mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between instruction fetch (IF) and the load/store path driven by control_bus_t fields dmem_rd, dmem_wr and ld_st_funct3.
- Sequences each access through a req/ready handshake and stalls the losing requester.
- Aligns store data and generates byte strobes; sign/zero-extends load data.
- Sits between the pipeline IF/MEM stages and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_lsu_align.sv | 26 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared funct3 encodings, arbiter states and memory request record
package mem_port_arbiter_pkg;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} arb_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } mem_req_t;
  function automatic logic funct3_legal(input logic [2:0] f3);
    return f3 inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction
endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// lsu_align: store lane replication/strobes, load lane extraction with sign/zero extension
module lsu_align (
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);
  logic [1:0]  sz;
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;
  always_comb begin
    sz = i_funct3[1:0];
    sx = ~i_funct3[2];
    b = i_rdata[{i_addr, 3'b000} +: 8];
    h = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_strb = sz == 2'd0 ? 4'b0001 << i_addr : sz == 2'd1 ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    o_wdata = sz == 2'd0 ? {4{i_wdata[7:0]}} : sz == 2'd1 ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = sz == 2'd0 ? {{24{sx & b[7]}}, b} : sz == 2'd1 ? {{16{sx & h[15]}}, h} : i_rdata;
    o_misaligned = (sz == 2'd1 & i_addr[0]) | (sz == 2'd2 & |i_addr);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store,
// with a burst limit so a pending fetch is not starved by back-to-back data accesses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NB_WORD        = 32,
  parameter int NB_ADDR        = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_if_req,
  input  logic [NB_ADDR-1:0] i_if_addr,
  output logic [NB_WORD-1:0] o_if_rdata,
  output logic               o_if_valid,
  output logic               o_if_stall,
  input  logic               i_lsu_rd,
  input  logic               i_lsu_wr,
  input  logic [2:0]         i_lsu_funct3,
  input  logic [NB_ADDR-1:0] i_lsu_addr,
  input  logic [NB_WORD-1:0] i_lsu_wdata,
  output logic [NB_WORD-1:0] o_lsu_rdata,
  output logic               o_lsu_valid,
  output logic               o_lsu_err,
  output logic               o_lsu_stall,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [NB_ADDR-1:0] o_mem_addr,
  output logic [NB_WORD-1:0] o_mem_wdata,
  output logic [3:0]         o_mem_strb,
  input  logic [NB_WORD-1:0] i_mem_rdata,
  input  logic               i_mem_ready
);
  arb_state_t   state_q, state_d;
  mem_req_t     mreq_q, mreq_d;
  logic         data_q, data_d, err_q, err_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [2:0]   f3_q, f3_d;
  logic [1:0]   k_q, k_d;
  logic [NB_WORD-1:0] lsu_rdata_q, lsu_rdata_d, if_rdata_q, if_rdata_d;
  logic         idle, lsu_req, data_go, bad, al_mis;
  logic [3:0]   al_strb;
  logic [31:0]  al_wdata, al_rdata;

  assign idle    = state_q == IDLE;
  assign lsu_req = i_lsu_rd | i_lsu_wr;
  assign data_go = lsu_req & ~(i_if_req & cnt_q == 4'(MAX_DATA_BURST));
  assign bad     = (i_lsu_rd & i_lsu_wr) | ~funct3_legal(i_lsu_funct3) | al_mis;

  // In IDLE the aligner shapes the incoming store; while waiting it extracts the returning load.
  lsu_align u_align (
    .i_funct3     (idle ? i_lsu_funct3 : f3_q),
    .i_addr       (idle ? i_lsu_addr[1:0] : k_q),
    .i_wdata      (i_lsu_wdata),
    .i_rdata      (i_mem_rdata),
    .o_strb       (al_strb),
    .o_wdata      (al_wdata),
    .o_rdata      (al_rdata),
    .o_misaligned (al_mis)
  );

  always_comb begin
    state_d     = state_q;
    mreq_d      = mreq_q;
    data_d      = data_q;
    err_d       = err_q;
    cnt_d       = i_if_req ? cnt_q : 4'd0;
    f3_d        = f3_q;
    k_d         = k_q;
    lsu_rdata_d = lsu_rdata_q;
    if_rdata_d  = if_rdata_q;
    case (state_q)
      IDLE: begin
        if (data_go) begin
          data_d      = 1'b1;
          err_d       = bad;
          f3_d        = i_lsu_funct3;
          k_d         = i_lsu_addr[1:0];
          cnt_d       = i_if_req ? cnt_q + 4'd1 : 4'd0;
          mreq_d      = bad ? mreq_q : '{addr: i_lsu_addr & ~NB_ADDR'(3), we: i_lsu_wr, wdata: al_wdata, strb: al_strb};
          lsu_rdata_d = bad ? '0 : lsu_rdata_q;
          state_d     = bad ? RESP : DATA;
        end else if (i_if_req) begin
          data_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = 4'd0;
          mreq_d  = '{addr: i_if_addr & ~NB_ADDR'(3), we: 1'b0, wdata: '0, strb: 4'hf};
          state_d = FETCH;
        end
      end
      DATA: if (i_mem_ready) begin
        lsu_rdata_d = mreq_q.we ? '0 : al_rdata;
        state_d     = RESP;
      end
      FETCH: if (i_mem_ready) begin
        if_rdata_d = i_mem_rdata;
        state_d    = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      mreq_q      <= '0;
      data_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 4'd0;
      f3_q        <= 3'd0;
      k_q         <= 2'd0;
      lsu_rdata_q <= '0;
      if_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mreq_q      <= mreq_d;
      data_q      <= data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      k_q         <= k_d;
      lsu_rdata_q <= lsu_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

  assign o_mem_req   = state_q == DATA | state_q == FETCH;
  assign o_mem_we    = o_mem_req & mreq_q.we;
  assign o_mem_addr  = mreq_q.addr;
  assign o_mem_wdata = mreq_q.wdata;
  assign o_mem_strb  = mreq_q.strb;
  assign o_lsu_valid = state_q == RESP & data_q;
  assign o_if_valid  = state_q == RESP & ~data_q;
  assign o_lsu_err   = o_lsu_valid & err_q;
  assign o_lsu_rdata = lsu_rdata_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_if_stall  = ~i_reset & i_if_req & ~o_if_valid;
  assign o_lsu_stall = ~i_reset & lsu_req & ~o_lsu_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboarded random + directed bench against a byte-level memory model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  logic        clk = 1'b0, rst;
  logic        i_if_req, i_lsu_rd, i_lsu_wr, i_mem_ready;
  logic [31:0] i_if_addr, i_lsu_addr, i_lsu_wdata, i_mem_rdata;
  logic [2:0]  i_lsu_funct3;
  logic [31:0] o_if_rdata, o_lsu_rdata, o_mem_addr, o_mem_wdata;
  logic        o_if_valid, o_if_stall, o_lsu_valid, o_lsu_err, o_lsu_stall, o_mem_req, o_mem_we;
  logic [3:0]  o_mem_strb;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NB_WORD(32), .NB_ADDR(32), .MAX_DATA_BURST(4)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_rdata(o_if_rdata),
    .o_if_valid(o_if_valid), .o_if_stall(o_if_stall),
    .i_lsu_rd(i_lsu_rd), .i_lsu_wr(i_lsu_wr), .i_lsu_funct3(i_lsu_funct3),
    .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata), .o_lsu_rdata(o_lsu_rdata),
    .o_lsu_valid(o_lsu_valid), .o_lsu_err(o_lsu_err), .o_lsu_stall(o_lsu_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_strb(o_mem_strb),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready)
  );

  int n_chk = 0, n_fail = 0;
  logic [7:0]  rb [0:1023];
  logic [31:0] mem_w [0:255];
  logic [32:0] exp_lsu_q [$];
  logic [31:0] exp_if_q [$];
  logic [32:0] mon_e;
  logic [31:0] mon_f, glog = 0;
  int gcnt = 0, n_req = 0, fixed_lat = -1, lat_cnt = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic [3:0]  last_strb = 0;
  logic        last_we = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory; access size is 1<<funct3[1:0] bytes, little endian.
  function automatic void ref_lsu(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic e, output logic [31:0] r);
    int n = 1 << f3[1:0];
    int ai = int'(a);
    e = (rd && wr) || (f3 inside {3'd3, 3'd6, 3'd7}) || (ai % n != 0);
    r = 0;
    if (!e && wr) for (int i = 0; i < n; i++) rb[ai + i] = wd[8*i +: 8];
    if (!e && rd) begin
      for (int i = 0; i < n; i++) r |= 32'(rb[ai + i]) << (8 * i);
      if (!f3[2] && n < 4 && r[8*n-1]) r |= 32'hFFFF_FFFF << (8 * n);
    end
  endfunction

  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    int b = int'(a) & ~3;
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  task automatic lsu_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output int c);
    logic e;
    logic [31:0] r;
    ref_lsu(rd, wr, f3, a, wd, e, r);
    exp_lsu_q.push_back({e, r});
    i_lsu_rd = rd; i_lsu_wr = wr; i_lsu_funct3 = f3; i_lsu_addr = a; i_lsu_wdata = wd;
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (o_lsu_valid || c >= 200) break;
      check("lsu_stall_hold", 32'(o_lsu_stall), 32'd1);
    end
    if (!o_lsu_valid) check("lsu_timeout", 32'(o_lsu_valid), 32'd1);
    else check("lsu_stall_release", 32'(o_lsu_stall), 32'd0);
    @(posedge clk); #1;
    i_lsu_rd = 0; i_lsu_wr = 0;
  endtask

  task automatic if_op(input logic [31:0] a, output int c);
    exp_if_q.push_back(ref_fetch(a));
    i_if_req = 1; i_if_addr = a;
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (o_if_valid || c >= 200) break;
      check("if_stall_hold", 32'(o_if_stall), 32'd1);
    end
    if (!o_if_valid) check("if_timeout", 32'(o_if_valid), 32'd1);
    else check("if_stall_release", 32'(o_if_stall), 32'd0);
    @(posedge clk); #1;
    i_if_req = 0;
  endtask

  // Memory responder with 0..3 cycle (or forced) latency; random data while not ready.
  initial forever begin
    @(negedge clk);
    if (rst || !o_mem_req) begin
      i_mem_ready = 0;
      i_mem_rdata = $urandom;
      lat_cnt = fixed_lat >= 0 ? fixed_lat : $urandom_range(0, 3);
    end else if (lat_cnt == 0) begin
      i_mem_ready = 1;
      i_mem_rdata = mem_w[o_mem_addr[9:2]];
    end else begin
      i_mem_ready = 0;
      i_mem_rdata = $urandom;
      lat_cnt--;
    end
  end

  always @(posedge clk) begin
    if (!rst && o_mem_req && i_mem_ready) begin
      last_addr <= o_mem_addr; last_we <= o_mem_we; last_strb <= o_mem_strb; last_wdata <= o_mem_wdata;
      if (o_mem_we)
        for (int b = 0; b < 4; b++)
          if (o_mem_strb[b]) mem_w[o_mem_addr[9:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (!rst && o_mem_req) n_req++;
    if (!rst && o_lsu_valid) begin
      glog = {glog[30:0], 1'b1}; gcnt++;
      if (exp_lsu_q.size() == 0) check("lsu_unexpected_valid", 32'(o_lsu_valid), 32'd0);
      else begin
        mon_e = exp_lsu_q.pop_front();
        check("lsu_err", 32'(o_lsu_err), 32'(mon_e[32]));
        check("lsu_rdata", o_lsu_rdata, mon_e[31:0]);
      end
    end
    if (!rst && o_if_valid) begin
      glog = {glog[30:0], 1'b0}; gcnt++;
      if (exp_if_q.size() == 0) check("if_unexpected_valid", 32'(o_if_valid), 32'd0);
      else begin
        mon_f = exp_if_q.pop_front();
        check("if_rdata", o_if_rdata, mon_f);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n0;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    rst = 1;
    i_if_req = 1; i_if_addr = 0; i_lsu_rd = 0; i_lsu_wr = 0; i_lsu_funct3 = 0;
    i_lsu_addr = 0; i_lsu_wdata = 0; i_mem_ready = 0; i_mem_rdata = 0;
    for (int i = 0; i < 1024; i++) rb[i] = 8'($urandom);
    rb[32'h100] = 8'h34; rb[32'h101] = 8'h12; rb[32'h102] = 8'hFF; rb[32'h103] = 8'h80;
    for (int w = 0; w < 256; w++) mem_w[w] = {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_if_stall", 32'(o_if_stall), 32'd0);
    check("rst_valids", {30'd0, o_lsu_valid, o_if_valid}, 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_mem_strb", 32'(o_mem_strb), 32'd0);
    i_if_req = 0;
    rst = 0;
    @(posedge clk); #1;

    fixed_lat = 2;
    lsu_op(1, 0, LB, 32'h103, 0, c);
    check("lb_mem_addr", last_addr, 32'h100);
    check("lb_rdata", o_lsu_rdata, 32'hFFFF_FF80);
    check("lb_cycles", 32'(c), 32'd5);
    lsu_op(1, 0, LBU, 32'h103, 0, c);
    check("lbu_rdata", o_lsu_rdata, 32'h0000_0080);

    fixed_lat = 0;
    lsu_op(0, 1, SH, 32'h202, 32'h0000_BEEF, c);
    check("sh_we", 32'(last_we), 32'd1);
    check("sh_strb", 32'(last_strb), 32'hC);
    check("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    check("sh_cycles", 32'(c), 32'd3);
    lsu_op(1, 0, LHU, 32'h202, 0, c);
    lsu_op(1, 0, LH, 32'h202, 0, c);

    n0 = n_req;
    lsu_op(0, 1, SW, 32'h301, 32'h1234_5678, c);
    check("sw_mis_cycles", 32'(c), 32'd2);
    lsu_op(1, 0, 3'b011, 32'h100, 0, c);
    check("ld_f3_011_cycles", 32'(c), 32'd2);
    lsu_op(1, 1, LW, 32'h100, 0, c);
    check("err_no_mem_req", 32'(n_req), 32'(n0));
    fixed_lat = -1;

    glog = 0; gcnt = 0;
    fork
      begin
        int c1;
        if_op(32'h40, c1);
      end
      begin
        int c2;
        for (int i = 0; i < 6; i++) lsu_op(1, 0, LW, 32'h100 + 32'(4 * i), 0, c2);
      end
    join
    check("burst_grant_count", 32'(gcnt), 32'd7);
    check("burst_grant_order", 32'(glog[6:0]), 32'h7B);

    fork
      begin
        int c3, g;
        for (int i = 0; i < 40; i++) begin
          g = $urandom_range(0, 2);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          if_op(32'($urandom_range(0, 255)), c3);
        end
      end
      begin
        int c4, g, r;
        for (int i = 0; i < 40; i++) begin
          g = $urandom_range(0, 2);
          if (g > 0) begin repeat (g) @(posedge clk); #1; end
          r = $urandom_range(0, 19);
          rd = r < 9 || r >= 18;
          wr = r >= 9;
          f3 = 3'($urandom_range(0, 7));
          if (wr && !rd && f3[2] && f3[1:0] < 2) f3[2] = 1'b0;
          a = 32'h100 + 32'($urandom_range(0, 32'h2F7));
          if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
          lsu_op(rd, wr, f3, a, $urandom, c4);
        end
      end
    join

    fixed_lat = 10;
    i_lsu_rd = 1; i_lsu_funct3 = LW; i_lsu_addr = 32'h104;
    @(negedge clk); @(negedge clk);
    check("rst_mid_req_before", 32'(o_mem_req), 32'd1);
    #1 rst = 1;
    #1;
    check("rst_mid_req_drop", 32'(o_mem_req), 32'd0);
    check("rst_mid_no_valid", 32'(o_lsu_valid), 32'd0);
    i_lsu_rd = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    fixed_lat = -1;
    @(posedge clk); #1;
    if_op(32'h10, c);
    repeat (3) @(negedge clk);
    check("lsu_queue_drained", 32'(exp_lsu_q.size()), 32'd0);
    check("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
